// File: rtl/frame_arbiter.sv
// frame_arbiter: round-robin, frame-granular arbiter that shares one
// decompression engine between N_CH AXI-stream sources. A granted channel
// owns the engine from its first beat through tlast. The arbiter then waits
// for the engine's finish pulse, or for the watchdog to expire, before it
// picks the next channel.
module frame_arbiter #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32,
    parameter int TO_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          s_tvalid,
    input  logic [N_CH-1:0]          s_tlast,
    input  logic [N_CH*DATA_W-1:0]   s_tdata,
    output logic [N_CH-1:0]          s_tready,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    output logic [DATA_W-1:0]        m_tdata,
    input  logic                     m_tready,
    input  logic                     finish,
    output logic [$clog2(N_CH)-1:0]  grant_id,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [15:0]              frame_cnt
);

    localparam int IDW = $clog2(N_CH);
    // The watchdog fires on the cycle in which it would otherwise step to all-ones.
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT
    } state_t;

    state_t            state;
    logic [IDW-1:0]    rr_ptr;
    logic [TO_W-1:0]   wd_cnt;
    logic [IDW-1:0]    pick;
    logic              pick_found;
    logic [IDW-1:0]    idx;
    logic              beat_fire;
    logic              last_fire;

    // Round-robin search: the first valid channel at or after rr_ptr, wrapping modulo N_CH.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = IDW'((int'(rr_ptr) + i) % N_CH);
            if (!pick_found && s_tvalid[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
    end

    // Only the granted channel reaches the engine, and only while a frame is streaming.
    always_comb begin
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tdata  = '0;
        s_tready = '0;
        if (state == ST_STREAM) begin
            m_tvalid           = s_tvalid[grant_id];
            m_tlast            = s_tlast[grant_id];
            m_tdata            = s_tdata[grant_id*DATA_W +: DATA_W];
            s_tready[grant_id] = m_tready;
        end
    end

    assign beat_fire = m_tvalid && m_tready;
    assign last_fire = beat_fire && m_tlast;
    assign busy      = (state != ST_IDLE);

    // Arbitration FSM. It also handles the round-robin pointer, the watchdog and the frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            rr_ptr      <= '0;
            wd_cnt      <= '0;
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick;
                        state    <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (last_fire) begin
                        if (grant_id == IDW'(N_CH - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= grant_id + 1'b1;
                        end
                        wd_cnt <= '0;
                        if (finish) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (finish) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= ST_IDLE;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_arbiter.sv
// tb_frame_arbiter: directed scoreboard bench for frame_arbiter.
// The stimulus pushes the expected grants and beats into queues. A monitor
// on the falling edge pops these queues and compares them with what the
// arbiter actually presents to the engine.
module tb_frame_arbiter;

    localparam int N_CH   = 4;
    localparam int DATA_W = 32;
    localparam int TO_W   = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic                    clk;
    logic                    rst;
    logic [N_CH-1:0]         s_tvalid;
    logic [N_CH-1:0]         s_tlast;
    logic [N_CH*DATA_W-1:0]  s_tdata;
    logic [N_CH-1:0]         s_tready;
    logic                    m_tvalid;
    logic                    m_tlast;
    logic [DATA_W-1:0]       m_tdata;
    logic                    m_tready;
    logic                    finish;
    logic [1:0]              grant_id;
    logic                    busy;
    logic                    timeout_err;
    logic [15:0]             frame_cnt;

    int    checks = 0;
    int    errors = 0;
    beat_t beatQ[$];
    int    grantQ[$];
    int    curGrant = 0;
    logic  prevBusy = 1'b0;

    frame_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tdata(s_tdata), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tready(m_tready),
        .finish(finish), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL sim_timeout: actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drive an n-beat frame on one channel. Each beat advances on its handshake.
    task automatic applyStimulus(input int ch, input int n, input logic [DATA_W-1:0] base, input bit toggle);
        int   beat;
        int   budget;
        logic fire;
        beat_t b;
        grantQ.push_back(ch);
        for (int k = 0; k < n; k++) begin
            b.data = base + DATA_W'(k);
            b.last = (k == n - 1);
            beatQ.push_back(b);
        end
        beat     = 0;
        budget   = 0;
        m_tready = toggle ? 1'b0 : 1'b1;
        s_tvalid[ch] = 1'b1;
        s_tlast[ch]  = (n == 1);
        s_tdata[ch*DATA_W +: DATA_W] = base;
        while (beat < n && budget < 64) begin
            @(negedge clk);
            fire = s_tready[ch] && m_tready;
            tick();
            budget++;
            if (fire) begin
                beat++;
                if (beat < n) begin
                    s_tdata[ch*DATA_W +: DATA_W] = base + DATA_W'(beat);
                    s_tlast[ch] = (beat == n - 1);
                end
            end
            if (toggle) m_tready = ~m_tready;
        end
        s_tvalid[ch] = 1'b0;
        s_tlast[ch]  = 1'b0;
        if (beat < n) begin
            errors++;
            checks++;
            $display("[TB] FAIL frame_handshake: actual=%0d beats required=%0d beats", beat, n);
        end
    endtask

    // Scoreboard monitor. It checks each new grant, ready routing and every transferred beat.
    always @(negedge clk) begin
        beat_t     b;
        logic [3:0] oh;
        if (rst) begin
            prevBusy = 1'b0;
        end else begin
            if (busy && !prevBusy) begin
                if (grantQ.size() == 0) begin
                    checkOutput("grant_unexpected", 64'(grant_id), 64'hFF);
                end else begin
                    curGrant = grantQ.pop_front();
                    checkOutput("grant_id", 64'(grant_id), 64'(curGrant));
                end
            end
            if (m_tvalid) begin
                oh = 4'b0001 << curGrant;
                checkOutput("tready_mirror", 64'(s_tready), m_tready ? 64'(oh) : 64'h0);
            end
            if (m_tvalid && m_tready) begin
                if (beatQ.size() == 0) begin
                    checkOutput("beat_unexpected", 64'(m_tdata), 64'hDEAD_0000_0000);
                end else begin
                    b = beatQ.pop_front();
                    checkOutput("beat_data", 64'(m_tdata), 64'(b.data));
                    checkOutput("beat_last", 64'(m_tlast), 64'(b.last));
                end
            end
            prevBusy = busy;
        end
    end

    initial begin
        beat_t b;
        rst      = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b0;
        finish   = 1'b0;
        tick();
        tick();
        tick();

        // Reset state.
        checkOutput("rst_s_tready", 64'(s_tready), 64'h0);
        checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_grant_id", 64'(grant_id), 64'h0);
        checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'h0);
        checkOutput("rst_timeout_err", 64'(timeout_err), 64'h0);
        rst = 1'b0;
        tick();

        // Test 1: ch2 sends a 3-beat frame and finish arrives on the 5th WAIT cycle.
        applyStimulus(2, 3, 32'hA000_0010, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            checkOutput("t1_wait_busy", 64'(busy), 64'h1);
            checkOutput("t1_wait_tready", 64'(s_tready), 64'h0);
            checkOutput("t1_wait_mvalid", 64'(m_tvalid), 64'h0);
            s_tvalid[0] = 1'b1;
            if (i == 5) finish = 1'b1;
            tick();
        end
        finish      = 1'b0;
        s_tvalid[0] = 1'b0;
        checkOutput("t1_frame_cnt", 64'(frame_cnt), 64'h1);
        checkOutput("t1_busy_drop", 64'(busy), 64'h0);
        checkOutput("t1_grant_hold", 64'(grant_id), 64'h2);
        tick();

        // Test 2: all channels valid with 1-beat frames and finish on tlast. Order is 0,1,2,3,0.
        doReset();
        checkOutput("t2_start_cnt", 64'(frame_cnt), 64'h0);
        for (int g = 0; g < 5; g++) begin
            grantQ.push_back(g % N_CH);
            b.data = 32'hC000_0000 + DATA_W'(g % N_CH);
            b.last = 1'b1;
            beatQ.push_back(b);
        end
        for (int c = 0; c < N_CH; c++) begin
            s_tdata[c*DATA_W +: DATA_W] = 32'hC000_0000 + DATA_W'(c);
        end
        s_tvalid = '1;
        s_tlast  = '1;
        m_tready = 1'b1;
        finish   = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        s_tvalid = '0;
        s_tlast  = '0;
        finish   = 1'b0;
        checkOutput("t2_frame_cnt", 64'(frame_cnt), 64'h5);
        checkOutput("t2_idle", 64'(busy), 64'h0);
        tick();

        // Test 3: ch1 sends a 4-beat frame while m_tready toggles.
        applyStimulus(1, 4, 32'hB000_0100, 1'b1);
        m_tready = 1'b1;
        finish   = 1'b1;
        tick();
        finish = 1'b0;
        checkOutput("t3_frame_cnt", 64'(frame_cnt), 64'h6);
        tick();

        // Test 4: finish is withheld, so the watchdog expires after 15 WAIT cycles.
        applyStimulus(2, 2, 32'hD000_0200, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            checkOutput("t4_wait_busy", 64'(busy), 64'h1);
            checkOutput("t4_no_early_to", 64'(timeout_err), 64'h0);
            tick();
        end
        checkOutput("t4_wait15_busy", 64'(busy), 64'h1);
        tick();
        checkOutput("t4_timeout_pulse", 64'(timeout_err), 64'h1);
        checkOutput("t4_timeout_idle", 64'(busy), 64'h0);
        checkOutput("t4_frame_cnt", 64'(frame_cnt), 64'h6);
        tick();
        checkOutput("t4_timeout_clear", 64'(timeout_err), 64'h0);

        // Test 5: reset on beat 2 of a 4-beat ch3 frame.
        grantQ.push_back(3);
        b.data = 32'hE000_0300;
        b.last = 1'b0;
        beatQ.push_back(b);
        m_tready    = 1'b1;
        s_tvalid[3] = 1'b1;
        s_tdata[3*DATA_W +: DATA_W] = 32'hE000_0300;
        tick();
        tick();
        s_tdata[3*DATA_W +: DATA_W] = 32'hE000_0301;
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        s_tvalid[3] = 1'b0;
        checkOutput("t5_s_tready", 64'(s_tready), 64'h0);
        checkOutput("t5_busy", 64'(busy), 64'h0);
        checkOutput("t5_grant_id", 64'(grant_id), 64'h0);
        checkOutput("t5_frame_cnt", 64'(frame_cnt), 64'h0);
        // rr_ptr must be 0 again, so ch1 wins over ch3.
        grantQ.push_back(1);
        b.data = 32'hE100_0001;
        b.last = 1'b1;
        beatQ.push_back(b);
        s_tdata[1*DATA_W +: DATA_W] = 32'hE100_0001;
        s_tdata[3*DATA_W +: DATA_W] = 32'hE300_0003;
        s_tvalid = 4'b1010;
        s_tlast  = 4'b1010;
        finish   = 1'b1;
        tick();
        tick();
        s_tvalid = '0;
        s_tlast  = '0;
        finish   = 1'b0;
        checkOutput("t5_rr_frame_cnt", 64'(frame_cnt), 64'h1);
        tick();

        // Test 6: a stray finish in IDLE, then a ch0 frame with finish 2 cycles after tlast.
        finish = 1'b1;
        tick();
        finish = 1'b0;
        checkOutput("t6_stray_idle", 64'(busy), 64'h0);
        checkOutput("t6_stray_cnt", 64'(frame_cnt), 64'h1);
        applyStimulus(0, 2, 32'hF000_0400, 1'b0);
        checkOutput("t6_wait1_cnt", 64'(frame_cnt), 64'h1);
        tick();
        finish = 1'b1;
        checkOutput("t6_wait2_cnt", 64'(frame_cnt), 64'h1);
        tick();
        finish = 1'b0;
        checkOutput("t6_final_cnt", 64'(frame_cnt), 64'h2);
        checkOutput("t6_idle", 64'(busy), 64'h0);
        tick();
        tick();

        checkOutput("beat_queue_drained", 64'(beatQ.size()), 64'h0);
        checkOutput("grant_queue_drained", 64'(grantQ.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
